// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared SIE types: PIDs, token record, status bits, CRC5 helpers
package types;

  localparam bit         USB_FULL_SPEED = 1'b0;
  localparam logic [4:0] CRC5_INIT      = 5'b11111;
  localparam logic [4:0] CRC5_POLY      = 5'b00101;
  localparam logic [4:0] CRC5_RESIDUAL  = 5'b01100;

  typedef enum logic [3:0] {
    RESERVED = 4'b0000,
    OUT      = 4'b0001,
    ACK      = 4'b0010,
    DATA0    = 4'b0011,
    PING     = 4'b0100,
    SOF      = 4'b0101,
    NYET     = 4'b0110,
    DATA2    = 4'b0111,
    SPLIT    = 4'b1000,
    IN       = 4'b1001,
    NAK      = 4'b1010,
    DATA1    = 4'b1011,
    PRE_ERR  = 4'b1100,
    SETUP    = 4'b1101,
    STALL    = 4'b1110,
    MDATA    = 4'b1111
  } pid_t;

  typedef struct packed {
    pid_t       pid;
    logic [3:0] pidx;
    logic [6:0] addr;
    logic [3:0] endp;
    logic [4:0] crc5;
  } token_t;

  typedef struct packed {
    logic token_done;
    logic pid_err;
    logic crc5_err;
  } usb_status_t;

  // Folds one received byte into the CRC5 register, LSB first as on the wire.
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
    logic [4:0] c;
    logic       fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = data[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    end
    return c;
  endfunction

  function automatic logic is_token_pid(input pid_t p);
    return (p == OUT) || (p == IN) || (p == SOF) || (p == SETUP);
  endfunction

endpackage

// File: rtl/usb_crc5.sv
// rtl/usb_crc5.sv - CRC5 register with per-byte update, init and residual check
module usb_crc5
  import types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       update,
  input  logic [7:0] data,
  output logic [4:0] crc,
  output logic       ok
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC5_INIT;
    end else if (init) begin
      crc <= CRC5_INIT;
    end else if (update) begin
      crc <= crc5_byte(crc, data);
    end
  end

  assign ok = (crc == CRC5_RESIDUAL);

endmodule

// File: rtl/usb_token_rx.sv
// rtl/usb_token_rx.sv - token packet receiver: PID check, token assembly, CRC5 check
module usb_token_rx
  import types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_active,
  input  logic       rx_error,
  output logic       pid_valid,
  output pid_t       pid,
  output token_t     token,
  output logic       token_valid,
  output logic       pid_err,
  output logic       crc5_err
);

  typedef enum logic [2:0] {IDLE, ADDR, ENDP_CRC, WAIT_EOP, DISCARD} state_t;

  state_t     state;
  logic       armed;
  token_t     work;
  logic       crc_init;
  logic       crc_update;
  logic       crc_ok;
  logic [4:0] crc_reg;

  assign crc_init   = (state == IDLE);
  assign crc_update = rx_valid && !rx_error && ((state == ADDR) || (state == ENDP_CRC));

  usb_crc5 u_crc5 (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (crc_init),
    .update (crc_update),
    .data   (rx_data),
    .crc    (crc_reg),
    .ok     (crc_ok)
  );

  // armed only after rx_active has been seen low, so a packet cut by reset is not re-parsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      armed       <= 1'b0;
      work        <= '0;
      pid         <= RESERVED;
      token       <= '0;
      pid_valid   <= 1'b0;
      token_valid <= 1'b0;
      pid_err     <= 1'b0;
      crc5_err    <= 1'b0;
    end else begin
      pid_valid   <= 1'b0;
      token_valid <= 1'b0;
      pid_err     <= 1'b0;
      crc5_err    <= 1'b0;
      if (!rx_active) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_valid && rx_active && armed) begin
            armed <= 1'b0;
            if (rx_error) begin
              state <= DISCARD;
            end else if (rx_data[7:4] == ~rx_data[3:0]) begin
              pid       <= pid_t'(rx_data[3:0]);
              pid_valid <= 1'b1;
              work.pid  <= pid_t'(rx_data[3:0]);
              work.pidx <= rx_data[7:4];
              state     <= is_token_pid(pid_t'(rx_data[3:0])) ? ADDR : DISCARD;
            end else begin
              pid_err <= 1'b1;
              state   <= DISCARD;
            end
          end
        end
        ADDR: begin
          if (rx_error) begin
            state <= DISCARD;
          end else if (rx_valid) begin
            work.addr    <= rx_data[6:0];
            work.endp[0] <= rx_data[7];
            state        <= ENDP_CRC;
          end else if (!rx_active) begin
            crc5_err <= 1'b1;
            state    <= IDLE;
          end
        end
        ENDP_CRC: begin
          if (rx_error) begin
            state <= DISCARD;
          end else if (rx_valid) begin
            work.endp[3:1] <= rx_data[2:0];
            work.crc5      <= rx_data[7:3];
            state          <= WAIT_EOP;
          end else if (!rx_active) begin
            crc5_err <= 1'b1;
            state    <= IDLE;
          end
        end
        WAIT_EOP: begin
          if (rx_error) begin
            state <= DISCARD;
          end else if (rx_valid) begin
            crc5_err <= 1'b1;
            state    <= DISCARD;
          end else if (!rx_active) begin
            if (crc_ok) begin
              token_valid <= 1'b1;
              token       <= work;
            end else begin
              crc5_err <= 1'b1;
            end
            state <= IDLE;
          end
        end
        DISCARD: begin
          if (!rx_active) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_token_rx.sv
// tb/tb_usb_token_rx.sv - directed self-checking bench for usb_token_rx
module tb_usb_token_rx;
  import types::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;
  logic       pid_valid;
  pid_t       pid;
  token_t     token;
  logic       token_valid;
  logic       pid_err;
  logic       crc5_err;

  int total = 0;
  int passed = 0;
  int n_pv = 0, n_pe = 0, n_tv = 0, n_ce = 0;
  int pv0, pe0, tv0, ce0;

  usb_token_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_active   (rx_active),
    .rx_error    (rx_error),
    .pid_valid   (pid_valid),
    .pid         (pid),
    .token       (token),
    .token_valid (token_valid),
    .pid_err     (pid_err),
    .crc5_err    (crc5_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pid_valid)   n_pv++;
    if (pid_err)     n_pe++;
    if (token_valid) n_tv++;
    if (crc5_err)    n_ce++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic sop();
    rx_active = 1'b1;
    tick(2);
  endtask

  task automatic snap();
    pv0 = n_pv;
    pe0 = n_pe;
    tv0 = n_tv;
    ce0 = n_ce;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_active = 1'b0; rx_error = 1'b0;
    tick(3);
    total++;
    if ({pid_valid, token_valid, pid_err, crc5_err} !== 4'b0000)
      $display("FAIL reset_pulses: got %b expected 0000", {pid_valid, token_valid, pid_err, crc5_err});
    else passed++;
    total++;
    if (pid !== RESERVED || token !== 24'h0)
      $display("FAIL reset_regs: got pid=%h token=%h expected pid=0 token=000000", pid, token);
    else passed++;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_setup();
    token_t exp;
    exp = '{pid: SETUP, pidx: 4'h2, addr: 7'd0, endp: 4'd0, crc5: 5'b00010};
    snap();
    sop();
    send(8'h2D);
    total++;
    if (pid_valid !== 1'b1 || pid !== SETUP)
      $display("FAIL setup_pid: got valid=%b pid=%h expected valid=1 pid=d", pid_valid, pid);
    else passed++;
    tick(); send(8'h00); tick(); send(8'h10); tick();
    rx_active = 1'b0;
    tick();
    total++;
    if (token_valid !== 1'b1)
      $display("FAIL setup_token_valid: got %b expected 1", token_valid);
    else passed++;
    total++;
    if (token !== exp)
      $display("FAIL setup_token: got %h expected %h", token, exp);
    else passed++;
    tick(2);
    total++;
    if (n_tv - tv0 !== 1 || n_ce - ce0 !== 0 || n_pv - pv0 !== 1)
      $display("FAIL setup_counts: got tv=%0d ce=%0d pv=%0d expected 1 0 1", n_tv - tv0, n_ce - ce0, n_pv - pv0);
    else passed++;
  endtask

  task automatic test_in_addr1();
    token_t exp;
    exp = '{pid: IN, pidx: 4'h6, addr: 7'd1, endp: 4'd0, crc5: 5'b11101};
    snap();
    sop();
    send(8'h69); tick(); send(8'h01); tick(); send(8'hE8); tick();
    rx_active = 1'b0;
    tick();
    total++;
    if (token_valid !== 1'b1 || token !== exp)
      $display("FAIL in_token: got valid=%b token=%h expected valid=1 token=%h", token_valid, token, exp);
    else passed++;
    tick(2);
  endtask

  task automatic test_out_good_bad();
    token_t exp;
    exp = '{pid: OUT, pidx: 4'hE, addr: 7'd0, endp: 4'd0, crc5: 5'b00010};
    snap();
    sop();
    send(8'hE1); tick(); send(8'h00); tick(); send(8'h10); tick();
    rx_active = 1'b0;
    tick(3);
    total++;
    if (n_tv - tv0 !== 1 || token.pid !== OUT)
      $display("FAIL out_good: got tv=%0d pid=%h expected tv=1 pid=1", n_tv - tv0, token.pid);
    else passed++;
    snap();
    sop();
    send(8'hE1); tick(); send(8'h00); tick(); send(8'h11); tick();
    rx_active = 1'b0;
    tick();
    total++;
    if (crc5_err !== 1'b1 || token_valid !== 1'b0)
      $display("FAIL out_bad_crc: got crc5_err=%b token_valid=%b expected 1 0", crc5_err, token_valid);
    else passed++;
    tick(2);
    total++;
    if (token !== exp || n_tv - tv0 !== 0)
      $display("FAIL out_bad_keep: got token=%h tv=%0d expected token=%h tv=0", token, n_tv - tv0, exp);
    else passed++;
  endtask

  task automatic test_pid_err();
    snap();
    sop();
    send(8'h2C);
    total++;
    if (pid_err !== 1'b1 || pid_valid !== 1'b0)
      $display("FAIL pid_err_pulse: got pid_err=%b pid_valid=%b expected 1 0", pid_err, pid_valid);
    else passed++;
    tick(); send(8'h00); tick(); send(8'h10); tick();
    rx_active = 1'b0;
    tick(3);
    total++;
    if (n_pe - pe0 !== 1 || n_pv - pv0 !== 0 || n_tv - tv0 !== 0 || n_ce - ce0 !== 0 || pid !== OUT)
      $display("FAIL pid_err_only: got pe=%0d pv=%0d tv=%0d ce=%0d pid=%h expected 1 0 0 0 pid=1",
               n_pe - pe0, n_pv - pv0, n_tv - tv0, n_ce - ce0, pid);
    else passed++;
  endtask

  task automatic test_data0();
    snap();
    sop();
    send(8'hC3);
    total++;
    if (pid_valid !== 1'b1 || pid !== DATA0)
      $display("FAIL data0_pid: got valid=%b pid=%h expected valid=1 pid=3", pid_valid, pid);
    else passed++;
    send(8'h2D); send(8'h00); send(8'h10); send(8'h55);
    rx_active = 1'b0;
    tick(3);
    total++;
    if (n_tv - tv0 !== 0 || n_ce - ce0 !== 0 || n_pe - pe0 !== 0)
      $display("FAIL data0_quiet: got tv=%0d ce=%0d pe=%0d expected 0 0 0", n_tv - tv0, n_ce - ce0, n_pe - pe0);
    else passed++;
  endtask

  task automatic test_short_long();
    snap();
    sop();
    send(8'h2D); tick(); send(8'h00); tick();
    rx_active = 1'b0;
    tick();
    total++;
    if (crc5_err !== 1'b1 || token_valid !== 1'b0)
      $display("FAIL short_token: got crc5_err=%b token_valid=%b expected 1 0", crc5_err, token_valid);
    else passed++;
    tick(2);
    snap();
    sop();
    send(8'h2D); send(8'h00); send(8'h10); send(8'h55);
    total++;
    if (crc5_err !== 1'b1)
      $display("FAIL long_token_4th: got crc5_err=%b expected 1", crc5_err);
    else passed++;
    tick();
    rx_active = 1'b0;
    tick(3);
    total++;
    if (n_ce - ce0 !== 1 || n_tv - tv0 !== 0)
      $display("FAIL long_token_once: got ce=%0d tv=%0d expected 1 0", n_ce - ce0, n_tv - tv0);
    else passed++;
  endtask

  task automatic test_rx_error();
    snap();
    sop();
    send(8'h2D); tick(); send(8'h00);
    rx_error = 1'b1; tick(); rx_error = 1'b0;
    send(8'h10); tick();
    rx_active = 1'b0;
    tick(3);
    total++;
    if (n_pv - pv0 !== 1 || n_tv - tv0 !== 0 || n_ce - ce0 !== 0 || n_pe - pe0 !== 0)
      $display("FAIL rx_error_silent: got pv=%0d tv=%0d ce=%0d pe=%0d expected 1 0 0 0",
               n_pv - pv0, n_tv - tv0, n_ce - ce0, n_pe - pe0);
    else passed++;
    snap();
    sop();
    send(8'h2D);
    rx_error = 1'b1; send(8'h00); rx_error = 1'b0;
    send(8'h10);
    rx_active = 1'b0;
    tick(3);
    total++;
    if (n_tv - tv0 !== 0 || n_ce - ce0 !== 0)
      $display("FAIL rx_error_with_byte: got tv=%0d ce=%0d expected 0 0", n_tv - tv0, n_ce - ce0);
    else passed++;
  endtask

  task automatic test_valid_at_eop();
    snap();
    sop();
    send(8'h2D); send(8'h00);
    rx_active = 1'b0;
    send(8'h10);
    total++;
    if (token_valid !== 1'b0 || crc5_err !== 1'b0)
      $display("FAIL eop_same_cycle_early: got tv=%b ce=%b expected 0 0", token_valid, crc5_err);
    else passed++;
    tick();
    total++;
    if (token_valid !== 1'b1)
      $display("FAIL eop_same_cycle_token: got %b expected 1", token_valid);
    else passed++;
    tick(2);
  endtask

  task automatic test_reset_mid();
    snap();
    sop();
    send(8'hE1); tick(); send(8'h00);
    rst_n = 1'b0;
    #1;
    total++;
    if (pid !== RESERVED || token !== 24'h0 || {pid_valid, token_valid, pid_err, crc5_err} !== 4'b0000)
      $display("FAIL reset_mid_outputs: got pid=%h token=%h pulses=%b expected 0 000000 0000",
               pid, token, {pid_valid, token_valid, pid_err, crc5_err});
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    snap();
    send(8'h10); tick();
    rx_active = 1'b0;
    tick(3);
    total++;
    if (n_tv - tv0 !== 0 || n_ce - ce0 !== 0 || n_pv - pv0 !== 0 || n_pe - pe0 !== 0)
      $display("FAIL reset_mid_ignore: got tv=%0d ce=%0d pv=%0d pe=%0d expected 0 0 0 0",
               n_tv - tv0, n_ce - ce0, n_pv - pv0, n_pe - pe0);
    else passed++;
    sop();
    send(8'hE1); send(8'h00); send(8'h10);
    rx_active = 1'b0;
    tick();
    total++;
    if (token_valid !== 1'b1 || token.pid !== OUT || token.crc5 !== 5'b00010)
      $display("FAIL reset_mid_recover: got tv=%b pid=%h crc5=%b expected 1 1 00010", token_valid, token.pid, token.crc5);
    else passed++;
    tick(2);
  endtask

  task automatic test_back_to_back();
    snap();
    rx_active = 1'b1; tick();
    send(8'h69); send(8'h01); send(8'hE8);
    rx_active = 1'b0; tick();
    rx_active = 1'b1; tick();
    send(8'h2D); send(8'h00); send(8'h10);
    rx_active = 1'b0;
    tick();
    total++;
    if (token_valid !== 1'b1 || token.pid !== SETUP)
      $display("FAIL b2b_second: got tv=%b pid=%h expected 1 d", token_valid, token.pid);
    else passed++;
    tick(2);
    total++;
    if (n_tv - tv0 !== 2 || n_pv - pv0 !== 2 || n_ce - ce0 !== 0)
      $display("FAIL b2b_counts: got tv=%0d pv=%0d ce=%0d expected 2 2 0", n_tv - tv0, n_pv - pv0, n_ce - ce0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_setup();
    test_in_addr1();
    test_out_good_bad();
    test_pid_err();
    test_data0();
    test_short_long();
    test_rx_error();
    test_valid_at_eop();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
